// File: rtl/synth_pkg.sv
// synth_pkg
//   Constants and types shared by the synth voice datapath blocks
//   (wavetable ROM, oscillator, mixer).
//   - LUT_BITS / DATA_W / NUM_BANDS / NUM_WAVES : wavetable geometry
//   - wave_e   : waveform encoding used on every waveform-select bus
//   - sample_t : signed audio sample
package synth_pkg;

    localparam int LUT_BITS  = 10;
    localparam int DATA_W    = 24;
    localparam int NUM_BANDS = 22;
    localparam int NUM_WAVES = 4;

    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        SAW      = 2'd1,
        TRIANGLE = 2'd2,
        SINE     = 2'd3
    } wave_e;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/band_select.sv
// band_select
//   Picks the band-limited table for a tuning word. The band is the
//   position of the highest set bit of the tuning word, offset by
//   BAND_BASE and clamped to [0, NUM_BANDS-1]. A zero tuning word
//   maps to band 0. Purely combinational.
//   Ports:
//     phase_inc  in   PHASE_W  tuning word (unsigned)
//     band       out  BAND_W   selected band
module band_select #(
    parameter int  PHASE_W   = 32,
    parameter int  BAND_BASE = 10,
    parameter int  NUM_BANDS = 22,
    localparam int BAND_W    = $clog2(NUM_BANDS)
) (
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [BAND_W-1:0]  band
);

    int msb;

    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // otherwise the unassigned paths would infer latches.
        msb  = 0;
        band = '0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int b = 0; b < PHASE_W; b++) begin
            if (phase_inc[b]) begin
                msb = b;
            end
        end
        if (msb <= BAND_BASE) begin
            band = '0;
        end else if (msb - BAND_BASE >= NUM_BANDS - 1) begin
            band = BAND_W'(NUM_BANDS - 1);
        end else begin
            band = BAND_W'(msb - BAND_BASE);
        end
    end

endmodule

// File: rtl/wavetable_osc.sv
// wavetable_osc
//   Phase-accumulating wavetable oscillator. On each sample tick it
//   snapshots the phase accumulator, reads two adjacent entries from the
//   registered wavetable ROM and emits one linearly interpolated sample.
//   Ports:
//     clk_i              in   1        system clock
//     rst_i              in   1        asynchronous active-high reset
//     sample_tick_i      in   1        sample-rate strobe
//     phase_inc_i        in   PHASE_W  tuning word
//     waveform_select_i  in   WAVE_W   waveform choice (wave_e)
//     lut_wave_o         out  WAVE_W   waveform to ROM (latched per read)
//     lut_band_o         out  BAND_W   band to ROM (latched per read)
//     lut_phase_o        out  LUT_BITS table index to ROM
//     lut_data_i         in   DATA_W   ROM data, one cycle after the index
//     sample_o           out  DATA_W   interpolated sample (signed)
//     sample_valid_o     out  1        one-cycle strobe, sample_o is new
//     overrun_o          out  1        sticky, tick arrived while busy
module wavetable_osc #(
    parameter int  LUT_BITS  = synth_pkg::LUT_BITS,
    parameter int  DATA_W    = synth_pkg::DATA_W,
    parameter int  NUM_WAVES = synth_pkg::NUM_WAVES,
    parameter int  NUM_BANDS = synth_pkg::NUM_BANDS,
    parameter int  PHASE_W   = 32,
    parameter int  FRAC_BITS = 8,
    parameter int  BAND_BASE = 10,
    localparam int WAVE_W    = $clog2(NUM_WAVES),
    localparam int BAND_W    = $clog2(NUM_BANDS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sample_tick_i,
    input  logic [PHASE_W-1:0]  phase_inc_i,
    input  logic [WAVE_W-1:0]   waveform_select_i,
    output logic [WAVE_W-1:0]   lut_wave_o,
    output logic [BAND_W-1:0]   lut_band_o,
    output logic [LUT_BITS-1:0] lut_phase_o,
    input  logic [DATA_W-1:0]   lut_data_i,
    output logic [DATA_W-1:0]   sample_o,
    output logic                sample_valid_o,
    output logic                overrun_o
);

    localparam int PROD_W = DATA_W + FRAC_BITS + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR0  = 3'd1,
        ADDR1  = 3'd2,
        CAP1   = 3'd3,
        INTERP = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [PHASE_W-1:0]       acc_q;
    logic [LUT_BITS-1:0]      idx_q;
    logic [FRAC_BITS-1:0]     frac_q;
    logic [WAVE_W-1:0]        wave_q;
    logic [BAND_W-1:0]        band_q;
    logic signed [DATA_W-1:0] s0_q, s1_q;

    logic [BAND_W-1:0]        band_raw;
    logic                     accept, busy_tick, cap0, cap1, do_interp, addr_next;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        sample_next;

    band_select #(
        .PHASE_W   (PHASE_W),
        .BAND_BASE (BAND_BASE),
        .NUM_BANDS (NUM_BANDS)
    ) u_band_select (
        .phase_inc (phase_inc_i),
        .band      (band_raw)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_tick_i) state_d = ADDR0;
            ADDR0:   state_d = ADDR1;
            ADDR1:   state_d = CAP1;
            CAP1:    state_d = INTERP;
            INTERP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        accept    = 1'b0;
        cap0      = 1'b0;
        cap1      = 1'b0;
        do_interp = 1'b0;
        addr_next = 1'b0;
        unique case (state_q)
            IDLE:    accept = sample_tick_i;
            ADDR0:   ;
            ADDR1:   begin cap0 = 1'b1; addr_next = 1'b1; end
            CAP1:    cap1 = 1'b1;
            INTERP:  do_interp = 1'b1;
            default: ;
        endcase
        // A tick in INTERP also counts as busy: the FSM only becomes
        // idle after that edge.
        busy_tick = sample_tick_i && (state_q != IDLE);
    end

    // ROM address: index i while the first read is presented, i+1 (wrapping
    // at the table end) for the second.
    assign lut_phase_o = addr_next ? (idx_q + LUT_BITS'(1)) : idx_q;
    assign lut_wave_o  = wave_q;
    assign lut_band_o  = band_q;

    // Linear interpolation. The difference needs one extra bit and the
    // fraction is zero-extended so it multiplies as a positive value; the
    // arithmetic shift floors, so the result stays between s0 and s1 and
    // fits back into DATA_W.
    always_comb begin
        diff        = {s1_q[DATA_W-1], s1_q} - {s0_q[DATA_W-1], s0_q};
        prod        = PROD_W'(diff) * PROD_W'($signed({1'b0, frac_q}));
        sample_next = DATA_W'(prod >>> FRAC_BITS) + s0_q;
    end

    // ---------------- datapath ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q          <= '0;
            idx_q          <= '0;
            frac_q         <= '0;
            wave_q         <= '0;
            band_q         <= '0;
            // NOTE: the sample holding registers are reset too; they are
            // only two words and this keeps sample_o fully defined.
            s0_q           <= '0;
            s1_q           <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            if (accept) begin
                acc_q  <= acc_q + phase_inc_i;
                idx_q  <= acc_q[PHASE_W-1 -: LUT_BITS];
                frac_q <= acc_q[PHASE_W-LUT_BITS-1 -: FRAC_BITS];
                wave_q <= waveform_select_i;
                // Sine has a single table, always band 0.
                band_q <= (waveform_select_i == WAVE_W'(synth_pkg::SINE)) ? '0 : band_raw;
            end
            if (cap0) begin
                s0_q <= lut_data_i;
            end
            if (cap1) begin
                s1_q <= lut_data_i;
            end
            if (do_interp) begin
                sample_o       <= sample_next;
                sample_valid_o <= 1'b1;
            end
            if (busy_tick) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wavetable_osc.sv
// tb_wavetable_osc
//   Bench for wavetable_osc with a registered ROM model. Expected samples,
//   indices and bands come from a phase-accumulator reference using plain
//   integer arithmetic on the table contents.
module tb_wavetable_osc;

    logic        clk, rst, tick;
    logic [31:0] phase_inc;
    logic [1:0]  wave_sel, lut_wave;
    logic [4:0]  lut_band;
    logic [9:0]  lut_phase;
    logic [23:0] rom_q, sample;
    logic        sample_valid, overrun;

    logic [23:0] rom_mem [1024];
    logic [31:0] ref_acc;
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          n_valid = 0;

    wavetable_osc dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .sample_tick_i     (tick),
        .phase_inc_i       (phase_inc),
        .waveform_select_i (wave_sel),
        .lut_wave_o        (lut_wave),
        .lut_band_o        (lut_band),
        .lut_phase_o       (lut_phase),
        .lut_data_i        (rom_q),
        .sample_o          (sample),
        .sample_valid_o    (sample_valid),
        .overrun_o         (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered ROM: data for the index seen before an edge appears after it.
    always @(posedge clk) rom_q <= rom_mem[lut_phase];

    always @(posedge clk) if (sample_valid === 1'b1) n_valid <= n_valid + 1;

    // ---------------- reference model ----------------
    function automatic logic [23:0] model_sample(input logic [31:0] snap);
        int     i, j, f;
        longint a, b, r;
        i = int'(snap[31:22]);
        j = (i + 1) % 1024;
        f = int'(snap[21:14]);
        a = longint'($signed(rom_mem[i]));
        b = longint'($signed(rom_mem[j]));
        r = a + (((b - a) * f) >>> 8);
        return r[23:0];
    endfunction

    function automatic int model_band(input logic [31:0] inc, input logic [1:0] wave);
        longint m;
        if (wave == 2'd3) return 0;
        m = (inc == 0) ? 0 : $clog2(longint'(inc) + 1) - 1;
        m = m - 10;
        if (m < 0)  m = 0;
        if (m > 21) m = 21;
        return int'(m);
    endfunction

    task automatic fill_ramp;
        for (int k = 0; k < 1024; k++) rom_mem[k] = 24'(k << 8);
    endtask

    task automatic fill_random;
        for (int k = 0; k < 1024; k++) rom_mem[k] = 24'($urandom);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1; tick = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_acc = '0;
    endtask

    // One full read with timing checks; tick sampled at edge T.
    task automatic do_read(input logic [31:0] inc, input logic [1:0] wave, input string tag);
        logic [31:0] snap;
        logic [9:0]  idx, idx1;
        logic [23:0] exp_s;
        logic [4:0]  exp_b;
        int          v0;
        snap    = ref_acc;
        ref_acc = ref_acc + inc;
        idx     = snap[31:22];
        idx1    = 10'((int'(idx) + 1) % 1024);
        exp_s   = model_sample(snap);
        exp_b   = 5'(model_band(inc, wave));
        @(negedge clk);
        tick = 1'b1; phase_inc = inc; wave_sel = wave;
        @(posedge clk); #1;
        tick = 1'b0; v0 = n_valid;
        phase_inc = $urandom; wave_sel = 2'($urandom);   // mid-read changes must not matter
        n_cmp++; if (lut_phase !== idx)  begin n_err++; $display("FAIL %s idx0: got %0d want %0d", tag, lut_phase, idx); end
        n_cmp++; if (lut_wave !== wave)  begin n_err++; $display("FAIL %s wave: got %0d want %0d", tag, lut_wave, wave); end
        n_cmp++; if (lut_band !== exp_b) begin n_err++; $display("FAIL %s band: got %0d want %0d", tag, lut_band, exp_b); end
        @(posedge clk); #1;
        n_cmp++; if (lut_phase !== idx1) begin n_err++; $display("FAIL %s idx1: got %0d want %0d", tag, lut_phase, idx1); end
        n_cmp++; if (lut_band !== exp_b || lut_wave !== wave) begin n_err++; $display("FAIL %s hold: got %0d/%0d want %0d/%0d", tag, lut_wave, lut_band, wave, exp_b); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL %s early_valid: got %b want 0", tag, sample_valid); end
        @(posedge clk); #1;
        n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL %s valid_T4: got %b want 1", tag, sample_valid); end
        n_cmp++; if (sample !== exp_s) begin n_err++; $display("FAIL %s sample: got %h want %h", tag, sample, exp_s); end
        @(posedge clk); #1;
        n_cmp++; if (sample_valid !== 1'b0 || sample !== exp_s) begin n_err++; $display("FAIL %s hold_sample: got %b/%h want 0/%h", tag, sample_valid, sample, exp_s); end
        n_cmp++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL %s valid_count: got %0d want 1", tag, n_valid - v0); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #3 rst = 1'b1; tick = 1'b1; phase_inc = 32'hFFFF_FFFF; wave_sel = 2'd1;
        #1;
        n_cmp++; if ({lut_wave, lut_band, lut_phase} !== '0) begin n_err++; $display("FAIL reset_lut: got %h want 0", {lut_wave, lut_band, lut_phase}); end
        n_cmp++; if ({sample, sample_valid, overrun} !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", {sample, sample_valid, overrun}); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({lut_phase, sample_valid, overrun} !== '0) begin n_err++; $display("FAIL reset_hold: got %h want 0", {lut_phase, sample_valid, overrun}); end
        tick = 1'b0;
        apply_reset;
    endtask

    task automatic test_ramp;
        apply_reset; fill_ramp;
        for (int k = 0; k < 4; k++) begin
            do_read(32'h0040_0000, 2'd0, "ramp");
            n_cmp++; if (sample !== 24'(k * 256)) begin n_err++; $display("FAIL ramp_const: got %0d want %0d", sample, k * 256); end
            repeat (2) @(posedge clk);
        end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ramp_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_half_step;
        apply_reset; fill_ramp;
        do_read(32'h0020_0000, 2'd1, "half_a");
        n_cmp++; if (sample !== 24'd0)   begin n_err++; $display("FAIL half_f0: got %0d want 0", sample); end
        do_read(32'h0020_0000, 2'd1, "half_b");
        n_cmp++; if (sample !== 24'd128) begin n_err++; $display("FAIL half_f128: got %0d want 128", sample); end
        do_read(32'h0020_0000, 2'd1, "half_c");
        n_cmp++; if (sample !== 24'd256) begin n_err++; $display("FAIL half_i1: got %0d want 256", sample); end
    endtask

    task automatic test_wrap;
        apply_reset; fill_ramp;
        do_read(32'hFFC0_0000, 2'd2, "wrap_a");
        do_read(32'h0040_0000, 2'd2, "wrap_b");
        n_cmp++; if (sample !== 24'd261888) begin n_err++; $display("FAIL wrap_s0: got %0d want 261888", sample); end
        do_read(32'h0040_0000, 2'd2, "wrap_c");
        n_cmp++; if (sample !== 24'd0) begin n_err++; $display("FAIL wrap_acc0: got %0d want 0", sample); end
    endtask

    task automatic test_band;
        logic [31:0] incs  [6] = '{32'd0, 32'h0000_0400, 32'h0000_8000, 32'h8000_0000, 32'h0010_0000, 32'h0010_0000};
        logic [1:0]  waves [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        int          bands [6] = '{0, 0, 5, 21, 0, 10};
        apply_reset; fill_random;
        for (int k = 0; k < 6; k++) begin
            do_read(incs[k], waves[k], "band");
            n_cmp++; if (lut_band !== 5'(bands[k])) begin n_err++; $display("FAIL band_const%0d: got %0d want %0d", k, lut_band, bands[k]); end
        end
    endtask

    task automatic test_random;
        apply_reset; fill_random;
        for (int k = 0; k < 25; k++) begin
            do_read($urandom >> $urandom_range(0, 31), 2'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_overrun;
        logic [31:0] snap, inc_a;
        logic [23:0] exp_s;
        int          v0;
        apply_reset; fill_random;
        inc_a = $urandom; snap = ref_acc; ref_acc = ref_acc + inc_a; exp_s = model_sample(snap);
        @(negedge clk); tick = 1'b1; phase_inc = inc_a; wave_sel = 2'd1;
        @(posedge clk); #1; tick = 1'b0; v0 = n_valid;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        @(posedge clk);
        @(negedge clk); tick = 1'b1; phase_inc = $urandom;
        @(posedge clk); #1; tick = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (sample_valid !== 1'b1 || sample !== exp_s) begin n_err++; $display("FAIL ovr_sample: got %b/%h want 1/%h", sample_valid, sample, exp_s); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL ovr_valid_count: got %0d want 1", n_valid - v0); end
        do_read($urandom, 2'd2, "after_ovr");
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] snap, inc_a;
        logic [23:0] exp_s;
        apply_reset; fill_random;
        inc_a = $urandom; snap = ref_acc; ref_acc = ref_acc + inc_a; exp_s = model_sample(snap);
        @(negedge clk); tick = 1'b1; phase_inc = inc_a; wave_sel = 2'd0;
        @(posedge clk); #1; tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); tick = 1'b1; phase_inc = $urandom;
        @(posedge clk); #1; tick = 1'b0;
        n_cmp++; if (sample_valid !== 1'b1 || sample !== exp_s) begin n_err++; $display("FAIL b2b_sample: got %b/%h want 1/%h", sample_valid, sample, exp_s); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
        do_read($urandom, 2'd3, "b2b_next");
    endtask

    task automatic test_reset_mid;
        int v0;
        apply_reset; fill_random;
        do_read(32'h8000_0000 | $urandom, 2'd1, "pre_rst");
        @(negedge clk); tick = 1'b1; phase_inc = 32'h8000_0000 | $urandom; wave_sel = 2'd1;
        @(posedge clk); #1; tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1; #1;
        n_cmp++; if ({lut_wave, lut_band, lut_phase} !== '0) begin n_err++; $display("FAIL mid_rst_lut: got %h want 0", {lut_wave, lut_band, lut_phase}); end
        n_cmp++; if ({sample, sample_valid, overrun} !== '0) begin n_err++; $display("FAIL mid_rst_out: got %h want 0", {sample, sample_valid, overrun}); end
        v0 = n_valid;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (n_valid !== v0 || sample_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_novalid: got %0d want 0", n_valid - v0); end
        @(negedge clk); rst = 1'b0; ref_acc = '0;
        do_read($urandom, 2'd0, "post_rst_a");
        do_read($urandom, 2'd2, "post_rst_b");
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; phase_inc = '0; wave_sel = '0; ref_acc = '0;
        fill_ramp;
        test_reset;
        test_ramp;
        test_half_step;
        test_wrap;
        test_band;
        test_random;
        test_overrun;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
